// File: rtl/bin_to_digit_latch_pkg.sv
// rtl/bin_to_digit_latch_pkg.sv - shared constants and types for the binary-to-BCD display feeder
//
// Purpose: state encoding, display constants and sizes shared by
// bin_to_digit_latch and bcd_add3_nibble.
// Ports: none (package).
package bin_to_digit_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic [3:0]  DIGIT_BLANK = 4'hF;
  localparam logic [19:0] MAX_DISP    = 20'd999999;
  localparam int          NUM_DIGITS  = 6;
  localparam int          BCD_W       = 4 * NUM_DIGITS;

endpackage

// File: rtl/bin_to_digit_latch_bcd_add3.sv
// rtl/bin_to_digit_latch_bcd_add3.sv - double-dabble nibble correction (add 3 when >= 5)
//
// Purpose: combinational correction applied to one BCD nibble before each
// left shift, so the shifted nibble carries correctly into the next decade.
// Ports:
//   nib_i  input  [3:0]  BCD nibble before correction
//   nib_o  output [3:0]  corrected nibble (no carry out; values 5..9 map to 8..12)
module bcd_add3_nibble (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_digit_latch.sv
// rtl/bin_to_digit_latch.sv - sequential binary to six-digit BCD converter with atomic output update
//
// Purpose: accepts a binary value over a valid/ready handshake, converts it
// one bit per div_clk with shift-add-3, then loads all six display digits
// together in a single cycle. Values above 999999 show OVF_CODE on every digit.
// Optional build macro: LEADING_ZERO_BLANK_EN - blank leading zeros (num1..num5)
// with DIGIT_BLANK on non-overflow loads.
// Ports:
//   rst        input   async reset, active-low
//   div_clk    input   block clock (display scanner clock)
//   bin_in     input   [BIN_W-1:0] binary value
//   bin_valid  input   bin_in valid; captured when bin_valid && bin_ready
//   bin_ready  output  high in IDLE only
//   num1..num6 output  [3:0] BCD digits, num1 = 10^5 ... num6 = 10^0
//   upd_done   output  one-cycle pulse in the cycle num* change
module bin_to_digit_latch
  import bin_to_digit_latch_pkg::*;
#(
  parameter int         BIN_W    = 20,
  parameter logic [3:0] OVF_CODE = 4'hE
) (
  input  logic             rst,
  input  logic             div_clk,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4,
  output logic [3:0]       num5,
  output logic [3:0]       num6,
  output logic             upd_done
);

  // Step counter only needs to reach BIN_W-1 (max 19).
  localparam int         CNT_W     = 5;
  localparam logic [4:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               upd_done_q, upd_done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   disp_load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  // Digits presented to the display at LOAD time (non-overflow case).
`ifdef LEADING_ZERO_BLANK_EN
  logic blank_run;
  always_comb begin
    disp_load = bcd_q;
    blank_run = 1'b1;
    // Walk from the most significant digit down to num5; num6 always shows.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (blank_run && (bcd_q[4*i +: 4] == 4'd0)) begin
        disp_load[4*i +: 4] = DIGIT_BLANK;
      end else begin
        blank_run = 1'b0;
      end
    end
  end
`else
  always_comb begin
    disp_load = bcd_q;
  end
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    upd_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bin_valid) begin
          shift_d = bin_in;
          bcd_d   = '0;
          step_d  = '0;
          ovf_d   = (32'(bin_in) > 32'(MAX_DISP));
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        // Correct every nibble, then shift the MSB of the binary value in.
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        step_d  = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        disp_d     = ovf_q ? {NUM_DIGITS{OVF_CODE}} : disp_load;
        upd_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      upd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      upd_done_q <= upd_done_d;
    end
  end

  assign bin_ready = (state_q == ST_IDLE);
  assign upd_done  = upd_done_q;
  assign num1      = disp_q[23:20];
  assign num2      = disp_q[19:16];
  assign num3      = disp_q[15:12];
  assign num4      = disp_q[11:8];
  assign num5      = disp_q[7:4];
  assign num6      = disp_q[3:0];

endmodule
